instr_mem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the instruction fetch unit. It receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory starting at byte address 0. It then validates a trailing XOR checksum and reports done or error, so the core can be released from reset only after a verified image is in memory.

---
 rtl/instr_mem_loader_if.sv | 23 ++
 rtl/instr_mem_loader.sv | 126 ++++++++++++
 tb/tb_instr_mem_loader.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the boot loader.
// The upstream/testbench side uses master; the loader uses slave.
interface instr_mem_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32
);
  logic [7:0]               byte_data;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [INSTR_WIDTH-1:0]   wr_data;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot loader: byte stream -> little-endian 32-bit words in instruction memory, then XOR checksum check.
// Write strobe one cycle after the 4th byte of a word; byte_ready only in LEN_LO/LEN_HI/DATA/CHECK, 1 byte/cycle peak.
module instr_mem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int N             = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR
  } state_t;

  localparam logic [16:0] N_MAX = 17'(N);

  state_t      state, state_next;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [7:0]  csum;

  logic        accept;
  logic        start_ok;
  logic        word_end;
  logic [15:0] len_in;
  logic [15:0] words_next;

  assign busy           = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
  assign bus.byte_ready = busy;
  assign done           = (state == DONE);
  assign error          = (state == ERROR);

  assign accept     = bus.byte_valid && busy;
  assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign word_end   = (state == DATA) && accept && (byte_cnt == 2'd3);
  assign len_in     = {bus.byte_data, len[7:0]};
  assign words_next = words_loaded + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_in} > N_MAX) state_next = ERROR;
          else if (len_in == 16'd0)   state_next = CHECK;
          else                        state_next = DATA;
        end
      end
      DATA: begin
        if (word_end && (words_next == len)) state_next = CHECK;
      end
      CHECK: begin
        if (accept) state_next = (bus.byte_data == csum) ? DONE : ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len          <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      words_loaded <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      if (start_ok) begin
        byte_cnt     <= '0;
        csum         <= '0;
        words_loaded <= '0;
      end
      if (accept) begin
        case (state)
          LEN_LO: begin
            len[7:0] <= bus.byte_data;
            csum     <= csum ^ bus.byte_data;
          end
          LEN_HI: begin
            len  <= len_in;
            csum <= csum ^ bus.byte_data;
          end
          DATA: begin
            csum     <= csum ^ bus.byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            // Earlier bytes shift down so the first byte lands in bits 7:0.
            word_buf <= {bus.byte_data, word_buf[23:8]};
            if (byte_cnt == 2'd3) begin
              bus.wr_en    <= 1'b1;
              bus.wr_addr  <= ADDRESS_WIDTH'({words_loaded, 2'b00});
              bus.wr_data  <= INSTR_WIDTH'({bus.byte_data, word_buf});
              words_loaded <= words_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus randomized loads vs a stream-level model.
module tb_instr_mem_loader;
  localparam int N = 32;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, error;
  logic [15:0] words_loaded;

  instr_mem_loader_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  instr_mem_loader #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] cap_addr[$], cap_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  int          exp_status;  // 1 = done, 2 = error
  int          exp_words;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      cap_addr.push_back(bus.wr_addr);
      cap_data.push_back(bus.wr_data);
    end
  end

  // Reference: decode the whole stream at once from its format rules.
  task automatic model_load(input bq_t s);
    int l;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_words = 0;
    l = int'({s[1], s[0]});
    if (l > N) begin
      exp_status = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * l; i++) x ^= s[i];
    for (int w = 0; w < l; w++) begin
      exp_addr.push_back(32'(4 * w));
      exp_data.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
    end
    exp_words  = l;
    exp_status = (s[2+4*l] == x) ? 1 : 2;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t = 0;
    ok = 1'b0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.byte_ready === 1'b1) begin
      @(negedge clk);
      ok = 1'b1;
    end
  endtask

  // gap < 0 selects a random 0..2 idle cycles after each byte.
  task automatic send_stream(input bq_t s, input int gap, output int n_acc);
    bit ok;
    int g;
    n_acc = 0;
    foreach (s[i]) begin
      send_byte(s[i], ok);
      bus.byte_valid = 1'b0;
      if (!ok) break;
      n_acc++;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) @(negedge clk);
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.byte_ready, bus.wr_en, busy, done, error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 00000", {bus.byte_ready, bus.wr_en, busy, done, error});
    end
    vectors++;
    if (bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0 || words_loaded !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_regs got addr=%h data=%h words=%0d exp 0", bus.wr_addr, bus.wr_data, words_loaded);
    end
  endtask

  // Good load, bad checksum, and the good load throttled with 3-cycle gaps.
  task automatic test_stream_loads;
    bq_t s;
    int  n_acc;
    for (int c = 0; c < 3; c++) begin
      s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
      if (c == 1) s[10] = 8'h74;
      model_load(s);
      cap_addr.delete();
      cap_data.delete();
      do_start;
      vectors++;
      if (busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL load%0d_start got busy=%b ready=%b exp 1 1", c, busy, bus.byte_ready);
      end
      send_stream(s, (c == 2) ? 3 : 0, n_acc);
      vectors++;
      if (n_acc != s.size()) begin
        miscompares++;
        $display("FAIL load%0d_accepted got %0d exp %0d", c, n_acc, s.size());
      end
      vectors++;
      if (cap_addr.size() != exp_addr.size()) begin
        miscompares++;
        $display("FAIL load%0d_write_count got %0d exp %0d", c, cap_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
        vectors++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("FAIL load%0d_write%0d got %h:%h exp %h:%h", c, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
        end
      end
      vectors++;
      if (done !== (exp_status == 1) || error !== (exp_status == 2) || busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL load%0d_status got done=%b err=%b busy=%b ready=%b exp status %0d", c, done, error, busy, bus.byte_ready, exp_status);
      end
      vectors++;
      if (words_loaded !== 16'(exp_words)) begin
        miscompares++;
        $display("FAIL load%0d_words got %0d exp %0d", c, words_loaded, exp_words);
      end
    end
  endtask

  task automatic test_empty_oversize;
    bq_t s;
    int  n_acc;
    bit  ok;
    s = '{8'h00, 8'h00, 8'h00};
    model_load(s);
    cap_addr.delete();
    cap_data.delete();
    do_start;
    send_stream(s, 0, n_acc);
    vectors++;
    if (n_acc != 3 || done !== (exp_status == 1) || error !== 1'b0 || cap_addr.size() != 0 || words_loaded !== 16'h0) begin
      miscompares++;
      $display("FAIL empty_load got acc=%0d done=%b err=%b writes=%0d words=%0d exp 3 1 0 0 0", n_acc, done, error, cap_addr.size(), words_loaded);
    end
    s = '{8'h21, 8'h00};
    model_load(s);
    do_start;
    send_stream(s, 0, n_acc);
    vectors++;
    if (n_acc != 2 || error !== (exp_status == 2) || done !== 1'b0 || bus.byte_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL oversize got acc=%0d err=%b done=%b ready=%b busy=%b exp 2 1 0 0 0", n_acc, error, done, bus.byte_ready, busy);
    end
    send_byte(8'h55, ok);
    bus.byte_valid = 1'b0;
    vectors++;
    if (ok || cap_addr.size() != 0) begin
      miscompares++;
      $display("FAIL oversize_stall got accepted=%0b writes=%0d exp 0 0", ok, cap_addr.size());
    end
  endtask

  task automatic test_reset_mid_word;
    bq_t s;
    int  n_acc;
    s = '{8'h02, 8'h00, 8'h93, 8'h00};
    cap_addr.delete();
    cap_data.delete();
    do_start;
    send_stream(s, 0, n_acc);
    reset = 1'b1;
    #2;
    vectors++;
    if ({bus.byte_ready, bus.wr_en, busy, done, error} !== 5'b0 || words_loaded !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_async got flags=%b words=%0d exp 0 0", {bus.byte_ready, bus.wr_en, busy, done, error}, words_loaded);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.byte_ready, bus.wr_en, busy, done, error} !== 5'b0 || bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0 || cap_addr.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_state got flags=%b addr=%h data=%h writes=%0d exp 0", {bus.byte_ready, bus.wr_en, busy, done, error}, bus.wr_addr, bus.wr_data, cap_addr.size());
    end
    s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    model_load(s);
    do_start;
    send_stream(s, 0, n_acc);
    vectors++;
    if (done !== 1'b1 || cap_addr.size() != 2 || words_loaded !== 16'd2) begin
      miscompares++;
      $display("FAIL midreset_reload got done=%b writes=%0d words=%0d exp 1 2 2", done, cap_addr.size(), words_loaded);
    end
    for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL midreset_write%0d got %h:%h exp %h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    bq_t s, head, tail;
    int  n_acc;
    s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    head = s[0:5];
    tail = s[6:10];
    model_load(s);
    cap_addr.delete();
    cap_data.delete();
    do_start;
    send_stream(head, 0, n_acc);
    do_start;
    vectors++;
    if (busy !== 1'b1 || words_loaded !== 16'd1 || cap_addr.size() != 1) begin
      miscompares++;
      $display("FAIL busy_start got busy=%b words=%0d writes=%0d exp 1 1 1", busy, words_loaded, cap_addr.size());
    end
    send_stream(tail, 0, n_acc);
    vectors++;
    if (done !== 1'b1 || words_loaded !== 16'(exp_words) || cap_addr.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL busy_start_finish got done=%b words=%0d writes=%0d exp 1 %0d %0d", done, words_loaded, cap_addr.size(), exp_words, exp_addr.size());
    end
    do_start;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || words_loaded !== 16'h0) begin
      miscompares++;
      $display("FAIL done_restart got done=%b busy=%b words=%0d exp 0 1 0", done, busy, words_loaded);
    end
    s = '{8'h00, 8'h00, 8'h00};
    send_stream(s, 0, n_acc);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL done_restart_finish got done=%b err=%b exp 1 0", done, error);
    end
  endtask

  task automatic test_random_loads;
    bq_t s;
    int  l, n_acc;
    logic [7:0] x;
    for (int it = 0; it < 20; it++) begin
      s.delete();
      if ($urandom_range(0, 5) == 0) l = N + 1 + int'($urandom_range(0, 200));
      else l = int'($urandom_range(0, N));
      s.push_back(8'(l));
      s.push_back(8'(l >> 8));
      if (l <= N) begin
        for (int k = 0; k < 4 * l; k++) s.push_back(8'($urandom));
        x = 8'h00;
        foreach (s[k]) x ^= s[k];
        if ($urandom_range(0, 2) == 0) x ^= 8'($urandom_range(1, 255));
        s.push_back(x);
      end
      model_load(s);
      cap_addr.delete();
      cap_data.delete();
      do_start;
      send_stream(s, -1, n_acc);
      vectors++;
      if (n_acc != s.size() || cap_addr.size() != exp_addr.size()) begin
        miscompares++;
        $display("FAIL rand%0d_counts got acc=%0d writes=%0d exp %0d %0d", it, n_acc, cap_addr.size(), s.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
        vectors++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("FAIL rand%0d_write%0d got %h:%h exp %h:%h", it, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
        end
      end
      vectors++;
      if (done !== (exp_status == 1) || error !== (exp_status == 2) || busy !== 1'b0 || words_loaded !== 16'(exp_words)) begin
        miscompares++;
        $display("FAIL rand%0d_status got done=%b err=%b busy=%b words=%0d exp status %0d words %0d", it, done, error, busy, words_loaded, exp_status, exp_words);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_stream_loads;
    test_empty_oversize;
    test_reset_mid_word;
    test_start_while_busy;
    test_random_loads;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
